// File: rtl/j1_progmem.sv
// Program memory and byte-serial image loader for the j1 core; holds the core until a full image is loaded.
// Optional checksum byte after the image is enabled by defining J1_PROGMEM_CHECKSUM_EN.
module j1_progmem #(
    parameter int unsigned AW        = 13,
    parameter logic [15:0] NOP_INSTR = 16'h6000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_next,
    output logic [15:0]   instr,
    output logic          core_hold,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic          ld_err
);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DAT_LO,
        DAT_HI,
`ifdef J1_PROGMEM_CHECKSUM_EN
        CSUM,
`endif
        RUN
    } state_t;

    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [15:0]   length;
    logic [15:0]   word_idx;
    logic [7:0]    lo_byte;
    logic [AW-1:0] wr_addr;
    logic          xfer;
    logic          wr_en;
    logic [15:0]   mem [0:(1 << AW) - 1];

`ifdef J1_PROGMEM_CHECKSUM_EN
    logic [7:0]    csum;
    logic          err_q;
    assign ld_err = err_q;
`else
    assign ld_err = 1'b0;
`endif

    assign ld_ready = (state != RUN) && !ld_start;
    assign xfer     = ld_valid && ld_ready;
    assign wr_en    = xfer && (state == DAT_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LEN_LO;
            core_hold <= 1'b1;
            ld_count  <= '0;
            length    <= '0;
            word_idx  <= '0;
            lo_byte   <= '0;
            wr_addr   <= '0;
`ifdef J1_PROGMEM_CHECKSUM_EN
            csum      <= '0;
            err_q     <= 1'b0;
`endif
        end else if (ld_start) begin
            state     <= LEN_LO;
            core_hold <= 1'b1;
            ld_count  <= '0;
`ifdef J1_PROGMEM_CHECKSUM_EN
            err_q     <= 1'b0;
`endif
        end else if (xfer) begin
            case (state)
                LEN_LO: begin
                    length[7:0] <= ld_data;
                    state       <= LEN_HI;
                end
                LEN_HI: begin
                    length[15:8] <= ld_data;
                    wr_addr      <= '0;
                    ld_count     <= '0;
                    word_idx     <= '0;
`ifdef J1_PROGMEM_CHECKSUM_EN
                    csum         <= '0;
`endif
                    if ({ld_data, length[7:0]} == 16'd0) begin
`ifdef J1_PROGMEM_CHECKSUM_EN
                        state     <= CSUM;
`else
                        state     <= RUN;
                        core_hold <= 1'b0;
`endif
                    end else begin
                        state <= DAT_LO;
                    end
                end
                DAT_LO: begin
                    lo_byte <= ld_data;
`ifdef J1_PROGMEM_CHECKSUM_EN
                    csum    <= csum ^ ld_data;
`endif
                    state   <= DAT_HI;
                end
                DAT_HI: begin
                    // word_idx tracks the full 16-bit length; ld_count saturates at the memory depth
                    wr_addr  <= wr_addr + AW'(1);
                    word_idx <= word_idx + 16'd1;
                    if (ld_count != COUNT_MAX)
                        ld_count <= ld_count + (AW+1)'(1);
`ifdef J1_PROGMEM_CHECKSUM_EN
                    csum     <= csum ^ ld_data;
`endif
                    if (word_idx + 16'd1 == length) begin
`ifdef J1_PROGMEM_CHECKSUM_EN
                        state     <= CSUM;
`else
                        state     <= RUN;
                        core_hold <= 1'b0;
`endif
                    end else begin
                        state <= DAT_LO;
                    end
                end
`ifdef J1_PROGMEM_CHECKSUM_EN
                CSUM: begin
                    if (ld_data == csum) begin
                        state     <= RUN;
                        core_hold <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                        state <= LEN_LO;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {ld_data, lo_byte};
    end

    // The posedge entering RUN still drives a NOP, so fetched code appears one cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr <= NOP_INSTR;
        else if (state == RUN)
            instr <= mem[pc_next];
        else
            instr <= NOP_INSTR;
    end

endmodule

// File: tb/tb_j1_progmem.sv
// Randomized bench for j1_progmem: two instances (AW=13 and AW=2) share one loader stream and are
// checked against an image-level memory model.
module tb_j1_progmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] pc_next;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;

    logic [15:0] instr_b, instr_s;
    logic        hold_b, hold_s, ready_b, ready_s, err_b, err_s;
    logic [13:0] count_b;
    logic [2:0]  count_s;

    always #5 clk = ~clk;

    j1_progmem #(.AW(13), .NOP_INSTR(16'h6000)) u_big (
        .clk(clk), .rst(rst), .pc_next(pc_next), .instr(instr_b), .core_hold(hold_b),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ready_b),
        .ld_count(count_b), .ld_err(err_b)
    );

    j1_progmem #(.AW(2), .NOP_INSTR(16'h6000)) u_small (
        .clk(clk), .rst(rst), .pc_next(pc_next[1:0]), .instr(instr_s), .core_hold(hold_s),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ready_s),
        .ld_count(count_s), .ld_err(err_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_b [8192];
    logic [15:0] exp_s [4];
    logic [15:0] img [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = b;
        #1;
        check("ld_ready", 32'(ready_b), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
    endtask

    task automatic send_held(input logic [7:0] b);
        check("hold_during_load", 32'(hold_b), 32'd1);
        send_byte(b);
    endtask

    // Sends length, words (and checksum byte when enabled), then checks release and counts.
    task automatic load_image(input bit bad);
        int          n   = img.size();
        logic [15:0] len = 16'(n);
        logic [7:0]  x   = '0;
        send_held(len[7:0]);
        send_held(len[15:8]);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w = img[i];
            send_held(w[7:0]);
            send_held(w[15:8]);
            x = x ^ w[7:0] ^ w[15:8];
        end
`ifdef J1_PROGMEM_CHECKSUM_EN
        send_held(bad ? (x ^ 8'h01) : x);
        check("ld_err", 32'(err_b), 32'(bad));
        check("ld_err_s", 32'(err_s), 32'(bad));
`else
        check("ld_err_off", 32'(err_b), 32'd0);
`endif
        for (int i = 0; i < n; i++) begin
            exp_b[i % 8192] = img[i];
            exp_s[i % 4]    = img[i];
        end
        check("hold_release", 32'(hold_b), 32'(bad));
        check("hold_release_s", 32'(hold_s), 32'(bad));
        check("count", 32'(count_b), 32'((n > 8192) ? 8192 : n));
        check("count_s", 32'(count_s), 32'((n > 4) ? 4 : n));
        check("nop_after_release", 32'(instr_b), 32'h6000);
        check("nop_after_release_s", 32'(instr_s), 32'h6000);
    endtask

    task automatic pulse_start(input bit with_byte);
        ld_start = 1'b1;
        ld_valid = with_byte;
        ld_data  = 8'h55;
        #1;
        check("ready_during_start", 32'(ready_b), 32'd0);
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        check("start_hold", 32'(hold_b), 32'd1);
        check("start_count", 32'(count_b), 32'd0);
        check("start_err", 32'(err_b), 32'd0);
    endtask

    task automatic fetch_at(input int a);
        pc_next  = 13'(a);
        ld_valid = 1'($urandom);
        ld_data  = 8'($urandom);
        @(negedge clk);
        check("fetch", 32'(instr_b), 32'(exp_b[a]));
        check("fetch_s", 32'(instr_s), 32'(exp_s[a % 4]));
        ld_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        pc_next  = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_instr", 32'(instr_b), 32'h6000);
        check("rst_hold", 32'(hold_b), 32'd1);
        check("rst_ready", 32'(ready_b), 32'd1);
        check("rst_count", 32'(count_b), 32'd0);
        check("rst_err", 32'(err_b), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_instr", 32'(instr_b), 32'h6000);
        check("idle_hold", 32'(hold_b), 32'd1);
        check("idle_ready_s", 32'(ready_s), 32'd1);

        // Two-word image straight after reset
        img = '{16'hF00F, 16'h0FF0};
        load_image(1'b0);
        check("ready_in_run", 32'(ready_b), 32'd0);
        fetch_at(0);
        fetch_at(1);

        // Zero-length image
        pulse_start(1'b0);
        img = {};
        load_image(1'b0);

        // Restart mid-image with a concurrent byte that must be dropped
        pulse_start(1'b0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        pulse_start(1'b1);
        img = '{16'h1234};
        load_image(1'b0);
        fetch_at(0);

        // Five words: wraps and saturates on the AW=2 instance only
        pulse_start(1'b0);
        img = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        load_image(1'b0);
        for (int a = 0; a < 5; a++) fetch_at(a);

`ifdef J1_PROGMEM_CHECKSUM_EN
        pulse_start(1'b0);
        img = '{16'h1234};
        load_image(1'b1);
        repeat (3) begin
            pc_next = 13'($urandom_range(0, 4));
            @(negedge clk);
            check("held_instr", 32'(instr_b), 32'h6000);
        end
        pulse_start(1'b0);
`endif

        // Reset during a load: two words already written survive, core stays held
        pulse_start(1'b0);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        exp_b[0] = 16'h2211; exp_b[1] = 16'h4433;
        exp_s[0] = 16'h2211; exp_s[1] = 16'h4433;
        rst = 1'b1;
        #1;
        check("midrst_hold", 32'(hold_b), 32'd1);
        check("midrst_ready", 32'(ready_b), 32'd1);
        check("midrst_count", 32'(count_b), 32'd0);
        check("midrst_instr", 32'(instr_b), 32'h6000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_hold", 32'(hold_b), 32'd1);
        img = '{16'hBEEF};
        load_image(1'b0);
        fetch_at(0);
        fetch_at(1);

        // Random images with idle gaps and ignored bytes during RUN
        repeat (8) begin
            int n;
            pulse_start(1'b0);
            n = $urandom_range(0, 10);
            img = {};
            for (int i = 0; i < n; i++) img.push_back(16'($urandom));
            load_image(1'b0);
            for (int k = 0; k < ((n < 8) ? n : 8); k++) fetch_at($urandom_range(0, n - 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/j1_progmem.md
Name: j1_progmem

Overview:
- Instruction-side neighbour of the j1 core: owns program memory and drives the core's instr input.
- Fetches one 16-bit instruction per cycle from the next-PC the core presents.
- Contains a byte-serial loader (valid/ready) that writes a length-prefixed program image into memory while holding the core.
- Releases the core once the image is complete.

Parameters:
- AW, 13, address width in words; memory depth is 2**AW. 13 matches the j1 PC width.
- NOP_INSTR, 16'h6000, instruction driven while the core is held (ALU no-op, T unchanged).

Ports:
- clk, input, 1, system clock; all state changes on posedge.
- rst, input, 1, asynchronous active-high reset.
- pc_next, input, AW, address the core fetches from on the next cycle.
- instr, output, 16, instruction to the core; registered.
- core_hold, output, 1, high while the program is not runnable; the integrating top freezes/resets the core with it.
- ld_start, input, 1, single-cycle pulse that begins a (re)load.
- ld_valid, input, 1, loader byte valid.
- ld_data, input, 8, loader byte.
- ld_ready, output, 1, loader may accept a byte this cycle.
- ld_count, output, AW+1, number of words written in the current or last load.
- ld_err, output, 1, checksum failure (see Optional Feature).

Behaviour:
- States: LEN_LO, LEN_HI, DAT_LO, DAT_HI, [CSUM], RUN.
- Reset: state=LEN_LO, instr=NOP_INSTR, core_hold=1, ld_count=0, ld_err=0, length=0, wr_addr=0. Memory contents are not reset.
- Byte transfer: occurs on a posedge with ld_valid && ld_ready.
  - ld_ready = (state != RUN) && !ld_start, combinational.
  - ld_data is ignored when ld_ready=0.
- Image format: length in words, 16-bit little-endian (LEN_LO then LEN_HI), then length words, each little-endian (DAT_LO then DAT_HI).
- LEN_HI transfer:
  - length==0: go to RUN (or CSUM if enabled).
  - otherwise: go to DAT_LO, wr_addr=0, ld_count=0.
- DAT_LO: latches the low byte.
- DAT_HI transfer:
  - writes {byte, lo} to mem[wr_addr]; wr_addr increments modulo 2**AW; ld_count increments.
  - When ld_count reaches length, go to RUN/CSUM; otherwise go to DAT_LO.
- Length above 2**AW: the address wraps and later words overwrite earlier ones. ld_count saturates at 2**AW, and the remaining words are still consumed until length is reached.
- ld_start, any state: next state LEN_LO, core_hold=1, ld_count=0, ld_err=0. Any concurrent byte is dropped (ld_ready is low that cycle).
- Fetch, state RUN: instr <= mem[pc_next] each posedge, giving 1-cycle latency from pc_next to instr.
- Fetch, any other state: instr <= NOP_INSTR.
- core_hold: deasserts on the posedge that enters RUN. The first instr fetched from memory appears one posedge later, so the core sees at least one NOP after release.
- Memory: single write port (loader) and single synchronous read port (fetch). Both never act in the same state, so there are no read/write collisions.
- rst mid-load: state returns immediately to LEN_LO. The partial image stays in memory, but core_hold=1 until a full reload completes.

Optional Feature:
- Macro: J1_PROGMEM_CHECKSUM_EN.
- Defined:
  - After the last data byte (or LEN_HI when length==0), state CSUM accepts one byte.
  - The expected value is the XOR of all data bytes, excluding the length bytes.
  - Match: go to RUN.
  - Mismatch: ld_err=1, stay held, state=LEN_LO. ld_err clears on ld_start or rst.
- Undefined: no CSUM state, ld_err tied 0, and the final data byte goes straight to RUN.

Test Plan:
- Reset then idle: instr=16'h6000, core_hold=1, ld_ready=1, ld_count=0.
- Load 02 00 0F F0 F0 0F, then pc_next=0, then pc_next=1:
  - mem[0]=16'hF00F, mem[1]=16'h0FF0.
  - core_hold falls after the 6th byte.
  - instr=F00F one cycle after pc_next=0, then 0FF0.
- Zero-length image 00 00: enters RUN after 2 bytes; ld_count=0.
- ld_start pulsed after the 3rd byte of an image, concurrent with ld_valid:
  - that byte is dropped;
  - the following bytes 01 00 34 12 load mem[0]=16'h1234; ld_count=1.
- AW=2, length 5 (words 1..5): mem[0]=5, mem[1..3]=2..4, ld_count=4, core released after 12 bytes.
- With J1_PROGMEM_CHECKSUM_EN:
  - image 01 00 34 12 with checksum 26: core released.
  - checksum 27: ld_err=1, core_hold stays 1, instr stays 16'h6000.
